// File: rtl/clock_mode_ctrl.sv
// Button front end and view/edit controller for the millennium clock display.
// Optional auto-repeat of INC strobes is enabled by defining AUTO_REPEAT_EN.
module clock_mode_ctrl #(
    parameter int unsigned DB_CYCLES      = 1000000,
    parameter int unsigned IDLE_TIMEOUT_S = 30,
    parameter int unsigned REPEAT_CYCLES  = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_inc,
    output logic       smh_dmy,
    output logic       dem_chinh,
    output logic [1:0] blink_led,
    output logic       run_en,
    output logic       inc_ss,
    output logic       inc_mm,
    output logic       inc_hh,
    output logic       inc_dd,
    output logic       inc_mo,
    output logic       inc_yy
);

    localparam int unsigned DB_W     = $clog2(DB_CYCLES);
    localparam int unsigned IDLE_W   = $clog2(IDLE_TIMEOUT_S + 1);
    localparam int unsigned NB       = 3;
    localparam int unsigned BTN_MODE = 0;
    localparam int unsigned BTN_SEL  = 1;
    localparam int unsigned BTN_INC  = 2;

    if (DB_CYCLES < 2 || IDLE_TIMEOUT_S < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("clock_mode_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        VIEW  = 2'b00,
        EDIT1 = 2'b01,
        EDIT2 = 2'b10,
        EDIT3 = 2'b11
    } state_t;

    logic [NB-1:0]     sync1, sync2, db, db_d, press;
    logic [DB_W-1:0]   db_cnt [NB];

    state_t            state, state_n;
    logic              smh_n;
    logic [IDLE_W-1:0] idle_cnt, idle_n;
    logic [5:0]        strobe, strobe_n;   // {yy, mo, dd, ss, mm, hh}
    logic [5:0]        field_c;

    // Synchronise, debounce and rising-edge detect each button
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            press <= '0;
            for (int unsigned i = 0; i < NB; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {btn_inc, btn_sel, btn_mode};
            sync2 <= sync1;
            db_d  <= db;
            press <= db & ~db_d;
            for (int unsigned i = 0; i < NB; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(2 * REPEAT_CYCLES);
    logic [RPT_W-1:0] rpt_cnt, rpt_n;
    logic             rpt_fire_c;

    // First repeat lands 2*REPEAT_CYCLES after the initial strobe, then every REPEAT_CYCLES
    assign rpt_fire_c = (state != VIEW) && db[BTN_INC]
                        && (rpt_cnt == RPT_W'(2 * REPEAT_CYCLES - 1));
`endif

    // Strobe for the field currently being edited
    always_comb begin
        field_c = '0;
        case (state)
            EDIT1:   field_c = smh_dmy ? 6'b001000 : 6'b000001;
            EDIT2:   field_c = smh_dmy ? 6'b010000 : 6'b000010;
            EDIT3:   field_c = smh_dmy ? 6'b100000 : 6'b000100;
            default: field_c = '0;
        endcase
    end

    // Next state: SEL > MODE > INC (> repeat) > idle tick
    always_comb begin
        state_n  = state;
        smh_n    = smh_dmy;
        idle_n   = idle_cnt;
        strobe_n = '0;
        if (press[BTN_SEL]) begin
            idle_n  = '0;
            state_n = state_t'(state + 2'd1);
        end else if (press[BTN_MODE]) begin
            idle_n = '0;
            if (state == VIEW) smh_n = ~smh_dmy;
        end else if (press[BTN_INC]) begin
            idle_n   = '0;
            strobe_n = field_c;
`ifdef AUTO_REPEAT_EN
        end else if (rpt_fire_c) begin
            idle_n   = '0;
            strobe_n = field_c;
`endif
        end else if (tick_1hz) begin
            if (idle_cnt >= IDLE_W'(IDLE_TIMEOUT_S - 1)) begin
                if (state != VIEW) begin
                    state_n = VIEW;
                    idle_n  = '0;
                end else begin
                    smh_n  = 1'b0;
                    idle_n = IDLE_W'(IDLE_TIMEOUT_S);
                end
            end else begin
                idle_n = idle_cnt + IDLE_W'(1);
            end
        end
`ifdef AUTO_REPEAT_EN
        rpt_n = '0;
        if (!db[BTN_INC] || state == VIEW || state_n != state || press[BTN_INC])
            rpt_n = '0;
        else if (rpt_fire_c)
            rpt_n = RPT_W'(REPEAT_CYCLES);
        else
            rpt_n = rpt_cnt + RPT_W'(1);
`endif
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= VIEW;
            smh_dmy   <= 1'b0;
            dem_chinh <= 1'b0;
            blink_led <= 2'b00;
            run_en    <= 1'b1;
            idle_cnt  <= '0;
            strobe    <= '0;
`ifdef AUTO_REPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            state     <= state_n;
            smh_dmy   <= smh_n;
            dem_chinh <= (state_n != VIEW);
            blink_led <= state_n;
            run_en    <= (state_n == VIEW);
            idle_cnt  <= idle_n;
            strobe    <= strobe_n;
`ifdef AUTO_REPEAT_EN
            rpt_cnt   <= rpt_n;
`endif
        end
    end

    assign {inc_yy, inc_mo, inc_dd, inc_ss, inc_mm, inc_hh} = strobe;

endmodule

// File: doc/clock_mode_ctrl.md
Name: clock_mode_ctrl

Overview:
User-interface controller for the millennium clock. Three raw push buttons (MODE, SEL, INC) pass through synchronisers and debouncers into a view/edit state machine. The block drives the display driver's view select, edit flag and blinking-field code. It also issues one-cycle increment strobes to the time/date counters and holds the main timekeeping counter while editing.

Parameters:
DB_CYCLES, 1000000, consecutive stable clocks needed to accept a button level change (20 ms at 50 MHz); minimum 2
IDLE_TIMEOUT_S, 30, tick_1hz pulses with no accepted press before auto-exit; minimum 1
REPEAT_CYCLES, 12500000, auto-repeat period in clocks (used only with AUTO_REPEAT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tick_1hz  in  1  one-cycle pulse once per second, from the timebase
btn_mode  in  1  raw MODE button, active-high, asynchronous
btn_sel  in  1  raw SEL button, active-high, asynchronous
btn_inc  in  1  raw INC button, active-high, asynchronous
smh_dmy  out  1  0 = hh:mm:ss view, 1 = dd-mo-yyyy view
dem_chinh  out  1  1 while in any edit state
blink_led  out  2  field being edited; 00 in VIEW
run_en  out  1  1 = main counter runs; 0 while editing
inc_ss, inc_mm, inc_hh  out  1 each  one-cycle increment strobes for seconds, minutes, hours
inc_dd, inc_mo, inc_yy  out  1 each  one-cycle increment strobes for day, month, year

Behaviour:
- Reset: synchronous, active-low. Sampled on the clk edge only. Asynchronous assertion has no effect until the next edge.
- Reset values: state=VIEW, smh_dmy=0, dem_chinh=0, blink_led=00, run_en=1, all inc_*=0, synchronisers=0, debounced levels=0, debounce/idle/repeat counters=0.
- Reset asserted mid-edit returns to the reset values on that edge. No inc strobe is issued on the reset edge.
- Per button:
  - 2-flop synchroniser.
  - The debounced level flips only after the synchroniser output has differed from it for DB_CYCLES consecutive clocks. Any agreeing sample clears the count.
  - A 0->1 flip of the debounced level produces a one-cycle internal press.
  - Pulses shorter than DB_CYCLES clocks produce no press.
- Latency: raw button rising and held stable -> registered output change exactly DB_CYCLES+3 clk edges after the first edge that samples it high. Releasing a button produces no action.
- FSM states: VIEW, EDIT1, EDIT2, EDIT3. All outputs are registered.
  - VIEW: MODE press toggles smh_dmy. SEL press -> EDIT1. INC press is ignored.
  - EDIT1/EDIT2/EDIT3: SEL press advances EDIT1->EDIT2->EDIT3->VIEW. MODE press is ignored (smh_dmy is locked while editing). INC press pulses one strobe for one cycle.
  - Strobe selection with smh_dmy=0: EDIT1 -> inc_hh, EDIT2 -> inc_mm, EDIT3 -> inc_ss.
  - Strobe selection with smh_dmy=1: EDIT1 -> inc_dd, EDIT2 -> inc_mo, EDIT3 -> inc_yy.
- Decoded outputs:
  - blink_led: VIEW=00, EDIT1=01, EDIT2=10, EDIT3=11.
  - dem_chinh = (state != VIEW); run_en = (state == VIEW).
- At most one inc_* is high in any cycle.
- Simultaneous presses in the same cycle: priority SEL > MODE > INC. Lower-priority presses are discarded, not queued.
- Idle timer:
  - Counts tick_1hz pulses and clears on any accepted press, including ignored ones.
  - A press and a tick in the same cycle clears the timer.
  - On reaching IDLE_TIMEOUT_S in an EDIT state: go to VIEW, smh_dmy unchanged, timer cleared.
  - On reaching IDLE_TIMEOUT_S in VIEW with smh_dmy=1: smh_dmy <- 0.
  - In VIEW with smh_dmy=0: the timer saturates at IDLE_TIMEOUT_S, with no action.
  - A timeout and a press in the same cycle: the press wins and the timeout is discarded.

Optional Feature:
Macro AUTO_REPEAT_EN.
- Defined:
  - While debounced INC stays high in an EDIT state, repeat strobes are issued to the currently selected field.
  - The first repeat comes 2*REPEAT_CYCLES clocks after the initial strobe; later repeats come every REPEAT_CYCLES clocks.
  - Each repeat clears the idle timer.
  - The repeat counter clears on INC release, on any state change, and on reset.
- Not defined: exactly one strobe per press; REPEAT_CYCLES is unused and no repeat counter is synthesised.

Test Plan:
All scenarios use DB_CYCLES=4, IDLE_TIMEOUT_S=3, REPEAT_CYCLES=8.
- Reset, then btn_mode high for 20 clocks -> smh_dmy goes 0->1 exactly 7 edges after the first sampling edge. A 3-clock glitch on btn_mode -> smh_dmy unchanged.
- smh_dmy=0, SEL presses x4 -> blink_led 01,10,11,00. dem_chinh 1,1,1,0. run_en 0,0,0,1.
- smh_dmy=1, EDIT2, INC press x2 -> exactly two single-cycle inc_mo pulses and no other inc_*. MODE press in EDIT2 -> smh_dmy stays 1.
- SEL and INC raw-high on the same clock in EDIT1 -> state EDIT2 and no inc strobe.
- EDIT3, no presses, 3 tick_1hz -> VIEW with blink_led=00. With smh_dmy=1 in VIEW, 3 ticks -> smh_dmy=0. Reset asserted mid-EDIT2 -> all outputs at reset values on that edge.
- With AUTO_REPEAT_EN: hold INC in EDIT1 (smh_dmy=0) for 40 clocks after the first strobe -> inc_hh pulses at +0, +16, +24, +32, +40. Without the macro -> one pulse only.
